// File: rtl/fifo_sync_flex_if.sv
// Bus bundle for fifo_sync_flex: flush, write/read requests, data and status.
// The producer/consumer side uses the master modport, the FIFO uses slave.
interface fifo_sync_flex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4
);
  logic                  clr_i;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_BITS:0]    fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr_i, data_in, w_en, r_en,
    input  data_out, fifo_empty, fifo_full, almost_full, almost_empty,
           fill_count, overflow, underflow
  );

  modport slave (
    input  clr_i, data_in, w_en, r_en,
    output data_out, fifo_empty, fifo_full, almost_full, almost_empty,
           fill_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with wrap-bit pointers, registered status, sticky
// overflow/underflow flags and a selectable registered or FWFT read port.
module fifo_sync_flex #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4,
  parameter int AF_LEVEL   = (2**ADDR_BITS) - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  fifo_sync_flex_if.slave   bus
);
  localparam int N = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0] AF_THR = (ADDR_BITS+1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_THR = (ADDR_BITS+1)'(AE_LEVEL);

  logic [ADDR_BITS:0]    r_wr_ptr;
  logic [ADDR_BITS:0]    r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [DATA_WIDTH-1:0] r_mem [N];

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [ADDR_BITS:0]    w_fill;
  logic [ADDR_BITS-1:0]  w_wr_addr;
  logic [ADDR_BITS-1:0]  w_rd_addr;

  // Status comes only from the registered pointers, never from w_en/r_en.
  assign w_wr_addr = r_wr_ptr[ADDR_BITS-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_BITS-1:0];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (w_wr_addr == w_rd_addr) &&
                     (r_wr_ptr[ADDR_BITS] != r_rd_ptr[ADDR_BITS]);
  assign w_fill    = r_wr_ptr - r_rd_ptr;

  // Flush blocks both operations; full blocks writes, empty blocks reads.
  assign w_wr_accept = bus.w_en && !w_full  && !bus.clr_i;
  assign w_rd_accept = bus.r_en && !w_empty && !bus.clr_i;

  // Pointer and sticky-flag state; flush outranks any request that cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clr_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (bus.w_en && w_full)  r_overflow  <= 1'b1;
      if (bus.r_en && w_empty) r_underflow <= 1'b1;
    end
  end

  // Storage array written on accepted writes only.
  // NOTE: the memory has no reset; the pointers alone define which entries
  // are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_wr_accept) r_mem[w_wr_addr] <= bus.data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head entry is shown combinationally; forced to zero while empty.
      assign bus.data_out = w_empty ? '0 : r_mem[w_rd_addr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_data;

      // Head entry captured on an accepted read, held otherwise.
      always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i)        r_data <= '0;
        else if (bus.clr_i)   r_data <= '0;
        else if (w_rd_accept) r_data <= r_mem[w_rd_addr];
      end

      assign bus.data_out = r_data;
    end
  endgenerate

  assign bus.fifo_empty   = w_empty;
  assign bus.fifo_full    = w_full;
  assign bus.fill_count   = w_fill;
  assign bus.almost_full  = (w_fill >= AF_THR);
  assign bus.almost_empty = (w_fill <= AE_THR);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
